// File: rtl/pwm_deadtime.sv
// Complementary high/low-side gate driver with programmable dead time and a sticky fault latch.
// Optional 2-flop input synchronizer on pwm_in when PWM_DEADTIME_SYNC_EN is defined.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                hs_out,
    output logic                ls_out,
    output logic                in_dead,
    output logic                fault_latched
);

    typedef enum logic [2:0] {
        IDLE,
        HS_ON,
        DEAD_TO_LS,
        LS_ON,
        DEAD_TO_HS
    } state_t;

    localparam logic [DT_WIDTH-1:0] ONE = DT_WIDTH'(1);

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                from_idle_q, from_idle_d;
    logic                fault_latched_q, fault_latched_d;
    logic [DT_WIDTH-1:0] d_load;
    logic                pwm_s;

`ifdef PWM_DEADTIME_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

    assign pwm_s = sync2_q;
`else
    assign pwm_s = pwm_in;
`endif

    // A programmed dead time of zero still guarantees one cycle of both gates off.
    assign d_load = (dead_time == '0) ? ONE : dead_time;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        from_idle_d     = from_idle_q;
        fault_latched_d = fault_latched_q;

        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end

        if (fault || !enable || fault_latched_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = pwm_s ? DEAD_TO_HS : DEAD_TO_LS;
                    cnt_d       = d_load;
                    from_idle_d = 1'b1;
                end
                HS_ON: begin
                    if (!pwm_s) begin
                        state_d     = DEAD_TO_LS;
                        cnt_d       = d_load;
                        from_idle_d = 1'b0;
                    end
                end
                LS_ON: begin
                    if (pwm_s) begin
                        state_d     = DEAD_TO_HS;
                        cnt_d       = d_load;
                        from_idle_d = 1'b0;
                    end
                end
                DEAD_TO_HS: begin
                    if (pwm_s) begin
                        if (cnt_q <= ONE) begin
                            state_d = HS_ON;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end else if (from_idle_q) begin
                        // No gate was on yet, so retarget instead of aborting.
                        state_d = DEAD_TO_LS;
                        cnt_d   = d_load;
                    end else begin
                        state_d = LS_ON;
                    end
                end
                DEAD_TO_LS: begin
                    if (!pwm_s) begin
                        if (cnt_q <= ONE) begin
                            state_d = LS_ON;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end else if (from_idle_q) begin
                        state_d = DEAD_TO_HS;
                        cnt_d   = d_load;
                    end else begin
                        state_d = HS_ON;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            from_idle_q     <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            from_idle_q     <= from_idle_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    // Gate drives decode purely from the state register, so reset drops them at once.
    assign hs_out        = (state_q == HS_ON);
    assign ls_out        = (state_q == LS_ON);
    assign in_dead       = (state_q == DEAD_TO_LS) || (state_q == DEAD_TO_HS);
    assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: stimulus pushes the expected {hs,ls,dead,flt} per cycle,
// a monitor pops and compares 2 time units after every rising edge.
module tb_pwm_deadtime;

`ifdef PWM_DEADTIME_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [3:0] E_IDLE = 4'b0000;
    localparam logic [3:0] E_HS   = 4'b1000;
    localparam logic [3:0] E_LS   = 4'b0100;
    localparam logic [3:0] E_DEAD = 4'b0010;
    localparam logic [3:0] E_FLT  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] dead_time = 8'd3;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic       hs_out, ls_out, in_dead, fault_latched;

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;
    logic [3:0] exp_q[$];

    pwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .dead_time    (dead_time),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .hs_out       (hs_out),
        .ls_out       (ls_out),
        .in_dead      (in_dead),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per rising edge while the scoreboard holds entries.
    always @(posedge clk) begin
        logic [3:0] act;
        logic [3:0] e;
        #2;
        cyc_no++;
        act = {hs_out, ls_out, in_dead, fault_latched};
        tests++;
        if (hs_out && ls_out) begin
            fails++;
            $display("FAIL shoot_through cycle %0d: hs_out=%b ls_out=%b required not both 1", cyc_no, hs_out, ls_out);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL outputs cycle %0d: got hs/ls/dead/flt=%b required %b", cyc_no, act, e);
            end
        end
    end

    // Push n expectations for the next n rising edges under the current inputs.
    task automatic cycles(input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] e);
        logic [3:0] act;
        act = {hs_out, ls_out, in_dead, fault_latched};
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got hs/ls/dead/flt=%b required %b", name, act, e);
        end
    endtask

    initial begin
        // Reset state, checked while rst is held.
        @(negedge clk);
        @(negedge clk);
        check_now("reset_hold", E_IDLE);
        rst = 1'b0;
        cycles(2, E_IDLE);

        // Start-up from IDLE with pwm low, dead_time 3.
        enable = 1'b1;
        cycles(3, E_DEAD);
        cycles(3, E_LS);

        // Toggle every 10 cycles, dead time 3.
        pwm_in = 1'b1; cycles(LAT, E_LS);   cycles(3, E_DEAD); cycles(7, E_HS);
        pwm_in = 1'b0; cycles(LAT, E_HS);   cycles(3, E_DEAD); cycles(7, E_LS);
        pwm_in = 1'b1; cycles(LAT, E_LS);   cycles(3, E_DEAD); cycles(7, E_HS);

        // dead_time 0 behaves as one cycle.
        dead_time = 8'd0;
        pwm_in = 1'b0; cycles(LAT, E_HS);   cycles(1, E_DEAD); cycles(3, E_LS);

        // dead_time 255, changed mid-gap: the captured value must still be used.
        dead_time = 8'd255;
        pwm_in = 1'b1; cycles(LAT, E_LS);   cycles(100, E_DEAD);
        dead_time = 8'd3;
        cycles(155, E_DEAD);
        cycles(3, E_HS);

        // Back to LS_ON, then a 2-cycle pulse with dead_time 5 must abort.
        pwm_in = 1'b0; cycles(LAT, E_HS);   cycles(3, E_DEAD); cycles(4, E_LS);
        dead_time = 8'd5;
        pwm_in = 1'b1;
        if (LAT != 0) begin
            cycles(2, E_LS);
            pwm_in = 1'b0;
            cycles(2, E_DEAD);
        end else begin
            cycles(2, E_DEAD);
            pwm_in = 1'b0;
        end
        cycles(4, E_LS);

        // Fault while in HS_ON, clear attempts, recovery with a dead gap.
        dead_time = 8'd3;
        pwm_in = 1'b1; cycles(LAT, E_LS);   cycles(3, E_DEAD); cycles(3, E_HS);
        fault = 1'b1;  cycles(1, E_FLT);
        fault = 1'b0;  cycles(3, E_FLT);
        fault = 1'b1;  fault_clr = 1'b1; cycles(1, E_FLT);
        fault = 1'b0;  cycles(1, E_IDLE);
        fault_clr = 1'b0;
        cycles(3, E_DEAD);
        cycles(3, E_HS);

        // Enable drop forces IDLE; re-enable goes through a full dead gap.
        enable = 1'b0; cycles(3, E_IDLE);
        enable = 1'b1; cycles(3, E_DEAD); cycles(2, E_HS);

        // Asynchronous reset in the middle of a dead gap.
        pwm_in = 1'b0; cycles(LAT, E_HS);   cycles(2, E_DEAD);
        #1 rst = 1'b1;
        #1 check_now("reset_async", E_IDLE);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycles(1, E_IDLE);
        enable = 1'b1;
        cycles(3, E_DEAD);
        cycles(3, E_LS);

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
